acc_trigger_scheduler: RTL

Sequences the AOM control flag for accumulation scans. On each laser-start rising edge it latches a burst configuration, waits a programmable delay, then issues a fixed number of AOM control pulses with programmable high time and period. It reports busy/done/error status and the count of pulses issued. Its aom_ctrl_flag_o output drives the downstream per-scan trigger counter.

---
 rtl/acc_trigger_scheduler.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/acc_trigger_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// acc_trigger_scheduler
// Sequences the AOM control flag for accumulation scans. A rising edge on
// laser_start_i latches the burst configuration, waits cfg_delay cycles, then
// emits cfg_num pulses of cfg_high cycles high with a cfg_period rise-to-rise
// spacing. Status flags and the issued-pulse count are reported alongside.
//
// Ports:
//   clk_i            system clock
//   rst_n_i          asynchronous active-low reset
//   laser_start_i    scan enable level; rising edge starts a burst
//   abort_i          level abort, takes effect in DELAY/HIGH/LOW
//   cfg_delay_i      cycles from start detection to first pulse
//   cfg_high_i       pulse high time in cycles
//   cfg_period_i     pulse period in cycles (rise to rise)
//   cfg_num_i        pulses per burst
//   aom_ctrl_flag_o  registered AOM control pulse train
//   busy_o           high while in DELAY/HIGH/LOW
//   done_o           one-cycle pulse on normal burst completion
//   err_o            sticky config error, cleared at next accepted start
//   ovr_o            sticky start-while-busy flag, cleared at next accepted start
//   trig_cnt_o       pulses issued in the current or last burst
// -----------------------------------------------------------------------------
module acc_trigger_scheduler #(
  parameter int CNT_W  = 32,
  parameter int HIGH_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              laser_start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  cfg_delay_i,
  input  logic [HIGH_W-1:0] cfg_high_i,
  input  logic [CNT_W-1:0]  cfg_period_i,
  input  logic [CNT_W-1:0]  cfg_num_i,
  output logic              aom_ctrl_flag_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ovr_o,
  output logic [CNT_W-1:0]  trig_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic             ls_d_r;
  logic [CNT_W-1:0] delay_r, delay_s;
  logic [CNT_W-1:0] high_r, high_s;
  logic [CNT_W-1:0] period_r, period_s;
  logic [CNT_W-1:0] num_r, num_s;
  logic [CNT_W-1:0] phase_cnt_r, phase_cnt_s;
  logic [CNT_W-1:0] trig_cnt_r, trig_cnt_s;
  logic             flag_r, flag_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             err_r, err_s;
  logic             ovr_r, ovr_s;

  logic             start_edge_s;
  logic             cfg_bad_s;
  logic [CNT_W-1:0] cfg_high_ext_s;
  logic [CNT_W-1:0] low_len_s;

  assign start_edge_s   = laser_start_i & ~ls_d_r;
  assign cfg_high_ext_s = CNT_W'(cfg_high_i);
  assign cfg_bad_s      = (cfg_high_i == {HIGH_W{1'b0}}) || (cfg_period_i <= cfg_high_ext_s);
  // Low phase length; period > high is guaranteed for any burst that runs.
  assign low_len_s      = period_r - high_r;

  // Next-state and next-output computation for the burst sequencer.
  always_comb begin
    state_s     = state_r;
    delay_s     = delay_r;
    high_s      = high_r;
    period_s    = period_r;
    num_s       = num_r;
    phase_cnt_s = phase_cnt_r;
    trig_cnt_s  = trig_cnt_r;
    flag_s      = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    err_s       = err_r;
    // A start edge during an active burst is only recorded, never accepted.
    if (busy_r && start_edge_s) begin
      ovr_s = 1'b1;
    end else begin
      ovr_s = ovr_r;
    end

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_edge_s) begin
          delay_s     = cfg_delay_i;
          high_s      = cfg_high_ext_s;
          period_s    = cfg_period_i;
          num_s       = cfg_num_i;
          trig_cnt_s  = CNT_ZERO;
          ovr_s       = 1'b0;
          phase_cnt_s = CNT_ONE;
          if (cfg_bad_s) begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
          end else begin
            err_s = 1'b0;
            if (cfg_num_i == CNT_ZERO) begin
              state_s = ST_DONE;
              done_s  = 1'b1;
            end else if (cfg_delay_i == CNT_ZERO) begin
              // Zero delay: the first pulse rises in the very next cycle.
              state_s    = ST_HIGH;
              flag_s     = 1'b1;
              busy_s     = 1'b1;
              trig_cnt_s = CNT_ONE;
            end else begin
              state_s = ST_DELAY;
              busy_s  = 1'b1;
            end
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_DELAY: begin
        if (abort_i) begin
          state_s = ST_IDLE;
        end else if (phase_cnt_r == delay_r) begin
          state_s     = ST_HIGH;
          flag_s      = 1'b1;
          busy_s      = 1'b1;
          trig_cnt_s  = trig_cnt_r + CNT_ONE;
          phase_cnt_s = CNT_ONE;
        end else begin
          busy_s      = 1'b1;
          phase_cnt_s = phase_cnt_r + CNT_ONE;
        end
      end

      ST_HIGH: begin
        if (abort_i) begin
          state_s = ST_IDLE;
        end else if (phase_cnt_r == high_r) begin
          // The last pulse skips its low phase and reports done immediately.
          if (trig_cnt_r == num_r) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            state_s     = ST_LOW;
            busy_s      = 1'b1;
            phase_cnt_s = CNT_ONE;
          end
        end else begin
          flag_s      = 1'b1;
          busy_s      = 1'b1;
          phase_cnt_s = phase_cnt_r + CNT_ONE;
        end
      end

      ST_LOW: begin
        if (abort_i) begin
          state_s = ST_IDLE;
        end else if (phase_cnt_r == low_len_s) begin
          state_s     = ST_HIGH;
          flag_s      = 1'b1;
          busy_s      = 1'b1;
          trig_cnt_s  = trig_cnt_r + CNT_ONE;
          phase_cnt_s = CNT_ONE;
        end else begin
          busy_s      = 1'b1;
          phase_cnt_s = phase_cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_IDLE;
      ls_d_r      <= 1'b0;
      delay_r     <= CNT_ZERO;
      high_r      <= CNT_ZERO;
      period_r    <= CNT_ZERO;
      num_r       <= CNT_ZERO;
      phase_cnt_r <= CNT_ZERO;
      trig_cnt_r  <= CNT_ZERO;
      flag_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      ovr_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      ls_d_r      <= laser_start_i;
      delay_r     <= delay_s;
      high_r      <= high_s;
      period_r    <= period_s;
      num_r       <= num_s;
      phase_cnt_r <= phase_cnt_s;
      trig_cnt_r  <= trig_cnt_s;
      flag_r      <= flag_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
      ovr_r       <= ovr_s;
    end
  end

  assign aom_ctrl_flag_o = flag_r;
  assign busy_o          = busy_r;
  assign done_o          = done_r;
  assign err_o           = err_r;
  assign ovr_o           = ovr_r;
  assign trig_cnt_o      = trig_cnt_r;

endmodule
